// File: rtl/player_turn_writer.sv
// -----------------------------------------------------------------------------
// player_turn_writer
//
// Write-side partner of the turn-indexed count mux in the ChickenCHACHACHA
// datapath. Owns the per-player counts p1..p4 and the turn slot T. It applies
// accepted move results to the active player's count, rotates the turn among
// the 2..4 active players, and reports the winner.
//
// Turn-slot mapping (same as the read mux), with L = last slot index:
//   slot T <  L -> player T+2
//   slot T == L -> player 1
//
// Parameters
//   WIN_CNT     count at which a player wins (<= 31)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   N           player-count code (00=2, 01=3, 1x=4), latched on start
//   start       one-cycle pulse, begins a game from IDLE or DONE
//   step_valid  move result offered for the active player
//   step_amt    squares to add (0..7)
//   step_ready  high in PLAY; a step transfers on step_valid && step_ready
//   turn_end    one-cycle pulse, passes the turn (PLAY only)
//   T           current turn slot
//   p1..p4_cnt  per-player counts
//   upd         pulse the cycle after an accepted step
//   win         pulse on entry to DONE
//   winner      winning player number minus 1, held until next start
//   playing     high in PLAY
// -----------------------------------------------------------------------------
module player_turn_writer #(
  parameter int WIN_CNT = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] N,
  input  logic       start,
  input  logic       step_valid,
  input  logic [2:0] step_amt,
  output logic       step_ready,
  input  logic       turn_end,
  output logic [1:0] T,
  output logic [4:0] p1_cnt,
  output logic [4:0] p2_cnt,
  output logic [4:0] p3_cnt,
  output logic [4:0] p4_cnt,
  output logic       upd,
  output logic       win,
  output logic [1:0] winner,
  output logic       playing
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] WIN_6 = 6'(WIN_CNT);

  logic [1:0] state_q, state_d;
  logic [1:0] n_q, n_d;
  logic [1:0] t_q, t_d;
  logic [4:0] cnt_q [4];
  logic [4:0] cnt_d [4];
  logic [1:0] winner_q, winner_d;
  logic       upd_q, upd_d;
  logic       win_q, win_d;

  logic [1:0] last_slot;
  logic [1:0] active;
  logic [5:0] sum;
  logic [5:0] sat;
  logic       accept;
  logic       win_now;

  // Index 0 is p1, index k is p(k+1). Slot T < L therefore maps to index T+1.
  always_comb begin
    case (n_q)
      2'b00:   last_slot = 2'd1;
      2'b01:   last_slot = 2'd2;
      default: last_slot = 2'd3;
    endcase
    active = (t_q < last_slot) ? t_q + 2'd1 : 2'd0;
  end

  // Sum in 6 bits so 31 + 7 cannot wrap before the saturation compare.
  assign sum     = {1'b0, cnt_q[active]} + {3'b000, step_amt};
  assign sat     = (sum >= WIN_6) ? WIN_6 : sum;
  assign accept  = (state_q == S_PLAY) && step_valid;
  assign win_now = accept && (sat == WIN_6);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    t_d      = t_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    upd_d    = accept;
    win_d    = win_now;

    case (state_q)
      S_IDLE, S_DONE: begin
        // start is the only way out; step/turn_end are not accepted here.
        if (start) begin
          state_d  = S_PLAY;
          n_d      = N;
          t_d      = 2'd0;
          cnt_d    = '{default: '0};
          winner_d = 2'd0;
        end
      end

      S_PLAY: begin
        if (accept) begin
          cnt_d[active] = sat[4:0];
        end
        if (win_now) begin
          // A winning step freezes T even if turn_end arrived with it.
          state_d  = S_DONE;
          winner_d = active;
        end else if (turn_end) begin
          t_d = (t_q >= last_slot) ? 2'd0 : t_q + 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the count array is only four registers and must read 0 after reset,
  // so it is reset like any other flop rather than treated as a memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= 2'd0;
      t_q      <= 2'd0;
      cnt_q    <= '{default: '0};
      winner_q <= 2'd0;
      upd_q    <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      t_q      <= t_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      upd_q    <= upd_d;
      win_q    <= win_d;
    end
  end

  assign step_ready = (state_q == S_PLAY);
  assign playing    = (state_q == S_PLAY);
  assign T          = t_q;
  assign p1_cnt     = cnt_q[0];
  assign p2_cnt     = cnt_q[1];
  assign p3_cnt     = cnt_q[2];
  assign p4_cnt     = cnt_q[3];
  assign upd        = upd_q;
  assign win        = win_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_player_turn_writer.sv
module tb_player_turn_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] N;
  logic       start;
  logic       step_valid;
  logic [2:0] step_amt;
  logic       step_ready;
  logic       turn_end;
  logic [1:0] T;
  logic [4:0] p1_cnt, p2_cnt, p3_cnt, p4_cnt;
  logic       upd;
  logic       win;
  logic [1:0] winner;
  logic       playing;

  player_turn_writer #(.WIN_CNT(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .N          (N),
    .start      (start),
    .step_valid (step_valid),
    .step_amt   (step_amt),
    .step_ready (step_ready),
    .turn_end   (turn_end),
    .T          (T),
    .p1_cnt     (p1_cnt),
    .p2_cnt     (p2_cnt),
    .p3_cnt     (p3_cnt),
    .p4_cnt     (p4_cnt),
    .upd        (upd),
    .win        (win),
    .winner     (winner),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: player index (0 = p1), expected count, expected win.
  typedef struct {
    int p;
    int c;
    bit w;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference game model (independent of the DUT state).
  int m_cnt[4];
  int m_t;
  int m_last;
  bit m_play;

  function automatic logic [4:0] dut_cnt(input int p);
    case (p)
      0:       return p1_cnt;
      1:       return p2_cnt;
      2:       return p3_cnt;
      default: return p4_cnt;
    endcase
  endfunction

  // One clock; outputs sampled 1 ns after the edge. The scoreboard is drained
  // here: an expected entry must appear as upd exactly one cycle after issue.
  task automatic tick();
    exp_t e;
    bit   exp_upd;
    @(posedge clk);
    #1;
    exp_upd = (sb.size() > 0);
    checks++;
    if (upd !== exp_upd) begin
      errors++;
      $display("FAIL upd: got %b expected %b", upd, exp_upd);
    end
    if (exp_upd) begin
      e = sb.pop_front();
      checks++;
      if (dut_cnt(e.p) !== 5'(e.c)) begin
        errors++;
        $display("FAIL sb_cnt p%0d: got %0d expected %0d", e.p + 1, dut_cnt(e.p), e.c);
      end
      checks++;
      if (win !== e.w) begin
        errors++;
        $display("FAIL sb_win: got %b expected %b", win, e.w);
      end
    end else begin
      checks++;
      if (win !== 1'b0) begin
        errors++;
        $display("FAIL win_idle: got %b expected 0", win);
      end
    end
  endtask

  task automatic do_start(input logic [1:0] n);
    N     = n;
    start = 1'b1;
    if (!m_play) begin
      m_cnt  = '{0, 0, 0, 0};
      m_t    = 0;
      m_last = (n == 2'b00) ? 1 : (n == 2'b01) ? 2 : 3;
      m_play = 1'b1;
    end
    tick();
    start = 1'b0;
    checks++;
    if (playing !== 1'b1 || step_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_play: playing %b ready %b expected 1 1", playing, step_ready);
    end
  endtask

  // Offer one step (optionally with turn_end) and push its expected result.
  task automatic do_step(input int amt, input bit te);
    exp_t e;
    step_valid = 1'b1;
    step_amt   = 3'(amt);
    turn_end   = te;
    if (m_play) begin
      e.p = (m_t < m_last) ? m_t + 1 : 0;
      e.c = (m_cnt[e.p] + amt > 24) ? 24 : m_cnt[e.p] + amt;
      e.w = (e.c == 24);
      m_cnt[e.p] = e.c;
      sb.push_back(e);
      if (e.w) m_play = 1'b0;
      else if (te) m_t = (m_t == m_last) ? 0 : m_t + 1;
    end
    tick();
    step_valid = 1'b0;
    turn_end   = 1'b0;
    checks++;
    if (T !== 2'(m_t)) begin
      errors++;
      $display("FAIL step_T: got %0d expected %0d", T, m_t);
    end
  endtask

  task automatic do_turn_end();
    turn_end = 1'b1;
    if (m_play) m_t = (m_t == m_last) ? 0 : m_t + 1;
    tick();
    turn_end = 1'b0;
    checks++;
    if (T !== 2'(m_t)) begin
      errors++;
      $display("FAIL turn_T: got %0d expected %0d", T, m_t);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_play = 1'b0;
    checks++;
    if ({p1_cnt, p2_cnt, p3_cnt, p4_cnt} !== 20'd0 || T !== 2'd0 || winner !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: cnts %0d %0d %0d %0d T %0d winner %0d expected all 0",
               p1_cnt, p2_cnt, p3_cnt, p4_cnt, T, winner);
    end
    checks++;
    if ({step_ready, upd, win, playing} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: ready/upd/win/playing %b expected 0000",
               {step_ready, upd, win, playing});
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    // Stimulus without start must do nothing.
    for (int i = 0; i < 4; i++) begin
      do_step(5, (i % 2) == 0);
    end
    checks++;
    if ({p1_cnt, p2_cnt, p3_cnt, p4_cnt} !== 20'd0 || T !== 2'd0 || step_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: cnts %0d %0d %0d %0d T %0d ready %b expected 0s",
               p1_cnt, p2_cnt, p3_cnt, p4_cnt, T, step_ready);
    end
  endtask

  task automatic test_three_player();
    do_start(2'b01);
    do_step(3, 1'b0);
    do_turn_end();
    do_step(4, 1'b0);
    do_turn_end();
    do_step(5, 1'b0);
    do_turn_end();
    checks++;
    if (p2_cnt !== 5'd3 || p3_cnt !== 5'd4 || p1_cnt !== 5'd5 || p4_cnt !== 5'd0 || T !== 2'd0) begin
      errors++;
      $display("FAIL rot3: p1..p4 %0d %0d %0d %0d T %0d expected 5 3 4 0 T 0",
               p1_cnt, p2_cnt, p3_cnt, p4_cnt, T);
    end
    // start in PLAY is ignored.
    N     = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (p2_cnt !== 5'd3 || p1_cnt !== 5'd5 || T !== 2'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL start_in_play: p1 %0d p2 %0d T %0d playing %b expected 5 3 0 1",
               p1_cnt, p2_cnt, T, playing);
    end
    do_turn_end();
    do_turn_end();
    do_turn_end();
  endtask

  task automatic test_win();
    apply_reset();
    do_start(2'b00);
    do_step(7, 1'b0);
    do_step(7, 1'b0);
    do_step(7, 1'b0);
    do_step(1, 1'b0);
    checks++;
    if (p2_cnt !== 5'd22) begin
      errors++;
      $display("FAIL pre_win: p2 got %0d expected 22", p2_cnt);
    end
    do_step(7, 1'b1);
    checks++;
    if (p2_cnt !== 5'd24 || winner !== 2'd1 || step_ready !== 1'b0 || playing !== 1'b0 || T !== 2'd0) begin
      errors++;
      $display("FAIL win: p2 %0d winner %0d ready %b playing %b T %0d expected 24 1 0 0 0",
               p2_cnt, winner, step_ready, playing, T);
    end
    // DONE: further steps and turn_ends change nothing; win does not repeat.
    do_step(5, 1'b1);
    do_step(0, 1'b0);
    checks++;
    if (p2_cnt !== 5'd24 || p1_cnt !== 5'd0 || T !== 2'd0 || winner !== 2'd1) begin
      errors++;
      $display("FAIL done_freeze: p1 %0d p2 %0d T %0d winner %0d expected 0 24 0 1",
               p1_cnt, p2_cnt, T, winner);
    end
  endtask

  task automatic test_simultaneous();
    do_start(2'b10);
    do_turn_end();
    do_turn_end();
    do_turn_end();
    do_step(2, 1'b1);
    checks++;
    if (p1_cnt !== 5'd2 || T !== 2'd0 || p2_cnt !== 5'd0) begin
      errors++;
      $display("FAIL simul: p1 %0d p2 %0d T %0d expected 2 0 0", p1_cnt, p2_cnt, T);
    end
  endtask

  task automatic test_back_to_back();
    // Valid held high for consecutive cycles, including a zero step.
    do_step(1, 1'b0);
    do_step(0, 1'b0);
    do_step(2, 1'b0);
    do_step(3, 1'b1);
    checks++;
    if (p2_cnt !== 5'd6 || T !== 2'd1) begin
      errors++;
      $display("FAIL b2b: p2 %0d T %0d expected 6 1", p2_cnt, T);
    end
  endtask

  task automatic test_n11_and_n_change();
    logic [1:0] seq [4];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    do_start(2'b11);
    for (int i = 0; i < 4; i++) begin
      do_turn_end();
      checks++;
      if (T !== seq[i]) begin
        errors++;
        $display("FAIL n11_T[%0d]: got %0d expected %0d", i, T, seq[i]);
      end
    end
    N = 2'b00;
    for (int i = 0; i < 4; i++) begin
      do_turn_end();
      checks++;
      if (T !== seq[i]) begin
        errors++;
        $display("FAIL nchg_T[%0d]: got %0d expected %0d", i, T, seq[i]);
      end
    end
    do_turn_end();
    do_turn_end();
    do_step(4, 1'b0);
    checks++;
    if (p4_cnt !== 5'd4) begin
      errors++;
      $display("FAIL nchg_p4: got %0d expected 4", p4_cnt);
    end
  endtask

  task automatic test_reset_restart();
    apply_reset();
    do_start(2'b01);
    do_turn_end();
    do_step(6, 1'b0);
    do_step(3, 1'b0);
    checks++;
    if (p3_cnt !== 5'd9) begin
      errors++;
      $display("FAIL p3_pre: got %0d expected 9", p3_cnt);
    end
    apply_reset();
    tick();
    checks++;
    if (p3_cnt !== 5'd0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: p3 %0d playing %b expected 0 0", p3_cnt, playing);
    end
    // Play to DONE, then restart with 3 players.
    do_start(2'b00);
    do_turn_end();
    do_step(7, 1'b0);
    do_step(7, 1'b0);
    do_step(7, 1'b0);
    do_step(5, 1'b0);
    checks++;
    if (p1_cnt !== 5'd24 || winner !== 2'd0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL p1_win: p1 %0d winner %0d playing %b expected 24 0 0", p1_cnt, winner, playing);
    end
    do_start(2'b01);
    checks++;
    if ({p1_cnt, p2_cnt, p3_cnt, p4_cnt} !== 20'd0 || T !== 2'd0) begin
      errors++;
      $display("FAIL restart: cnts %0d %0d %0d %0d T %0d expected 0s",
               p1_cnt, p2_cnt, p3_cnt, p4_cnt, T);
    end
    do_turn_end();
    do_step(2, 1'b0);
    checks++;
    if (p3_cnt !== 5'd2) begin
      errors++;
      $display("FAIL restart_p3: got %0d expected 2", p3_cnt);
    end
  endtask

  initial begin
    rst        = 1'b1;
    N          = 2'b00;
    start      = 1'b0;
    step_valid = 1'b0;
    step_amt   = 3'd0;
    turn_end   = 1'b0;
    m_play     = 1'b0;
    m_cnt      = '{0, 0, 0, 0};
    m_t        = 0;
    m_last     = 1;
    #12;

    test_reset();
    test_three_player();
    test_win();
    test_simultaneous();
    test_back_to_back();
    test_n11_and_n_change();
    test_reset_restart();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/player_turn_writer.md
# player_turn_writer

Write-side counterpart of the turn-indexed count multiplexer in the ChickenCHACHACHA game datapath. It owns the per-player count registers p1–p4 and the turn index T, using the same turn-slot-to-player mapping as the read mux. It applies accepted move results to the active player's count and rotates the turn among the 2–4 active players. It also detects the winning count and reports the winner to the game controller.

## Interface

**Parameters**
- WIN_CNT, default 24: count at which a player wins (must be ≤ 31).

**Ports**
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- N  in  2  player-count code: 00 = 2 players, 01 = 3, 10 = 4, 11 = 4. Latched on start.
- start  in  1  one-cycle pulse; begins a new game from IDLE or DONE.
- step_valid  in  1  move result offered for the active player.
- step_amt  in  3  squares to add, 0–7.
- step_ready  out  1  high only in PLAY; a step transfers when step_valid && step_ready.
- turn_end  in  1  one-cycle pulse; passes the turn. Honoured in PLAY only.
- T  out  2  current turn slot.
- p1_cnt, p2_cnt, p3_cnt, p4_cnt  out  5 each  per-player counts.
- upd  out  1  one-cycle pulse the cycle after an accepted step.
- win  out  1  one-cycle pulse on entry to DONE.
- winner  out  2  winning player number minus 1; holds until the next start.
- playing  out  1  high in PLAY.

## Operation

**Turn-slot mapping** (identical to the read mux). With L = last slot index (1, 2 or 3 for 2, 3 or 4 players):
- slot T < L addresses player T+2;
- slot T = L addresses p1.

Examples:
- 2 players: T0 → p2, T1 → p1.
- 3 players: T0 → p2, T1 → p3, T2 → p1.
- 4 players: T0 → p2, T1 → p3, T2 → p4, T3 → p1.

**FSM states and transitions**
- IDLE (reset state)
  - start: clear all counts, T ← 0, latch N → PLAY.
- PLAY
  - Accepted step: active count ← min(count + step_amt, WIN_CNT).
  - If the new count equals WIN_CNT: winner ← active player, → DONE.
  - turn_end: T ← (T == L) ? 0 : T + 1.
- DONE
  - Counts, T and winner frozen.
  - step_ready = 0; turn_end ignored.
  - start: restart exactly as from IDLE.

**Rules**
- Arithmetic is 6-bit internally, then saturates at WIN_CNT; 5-bit outputs never wrap.
- step_amt = 0 is still accepted, produces upd, and leaves the count unchanged.
- Inactive players' counts stay 0. No write ever targets a player outside the latched N.
- Step and turn_end in the same cycle: the step applies to the pre-advance player, then T advances.
  - If that step wins, the game enters DONE and T does not advance.
- N changes while in PLAY or DONE are ignored until the next start.
- start while in PLAY is ignored.
- start in the same cycle as step_valid or turn_end in IDLE/DONE: start wins; the step is not accepted (step_ready was 0).

## Timing

**Reset values** (rst asserted, effective immediately, asynchronously):
- state IDLE; T = 0; p1–p4_cnt = 0; winner = 0.
- step_ready = 0, upd = 0, win = 0, playing = 0.

Reset in mid-game discards the game. The first start after rst deasserts behaves normally.

**Latencies**
- start at edge k: playing = 1 and step_ready = 1 from cycle k+1.
- Step accepted at edge k: new count visible at k+1; upd high during k+1.
- A step can be accepted every cycle (full throughput).
- turn_end at edge k: new T visible at k+1.
- Winning step at edge k: win high and winner valid during k+1; step_ready = 0 and playing = 0 from k+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset and IDLE:** rst, then step_valid = 1, step_amt = 5 and turn_end pulses without start → all counts 0, T = 0, step_ready = 0, upd never asserted.
- **3-player rotation:** start with N = 01, then steps of 3, 4, 5 each followed by turn_end → p2 = 3, p3 = 4, p1 = 5, p4 = 0, T back to 0.
- **Saturation and win:** N = 00, WIN_CNT = 24. Give p2 22, then a step of 7 at T = 0 → p2 = 24, win pulses once, winner = 01, step_ready = 0; a later step_valid leaves counts unchanged.
- **Simultaneous events:** N = 10, T = 3, step 2 with turn_end in the same cycle → p1 += 2, T = 0, upd pulses.
- **N = 11 and N change mid-game:** start with N = 11, four turn_ends → T sequence 1, 2, 3, 0. Change N to 00 mid-game → rotation unchanged.
- **Reset mid-operation and restart:** rst during PLAY with p3 = 9 → all 0, IDLE. In DONE, start with N = 01 → counts cleared, T = 0, PLAY.
